bw_stream_checker: RTL and testbench

BW_STREAM_CHECKER -- requirements
Module: bw_stream_checker

---
 rtl/bw_stream_checker_pkg.sv | 38 +++
 rtl/bw_stream_checker_if.sv | 35 +++
 rtl/bw_stream_checker_lfsr16.sv | 34 +++
 rtl/bw_stream_checker.sv | 197 +++++++++++++++++++
 tb/tb_bw_stream_checker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bw_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bw_stream_checker_pkg
// Purpose : Shared definitions for the stream bandwidth checker: FSM state
//           encoding, default burst length, sequence-stamp width, LFSR seed
//           and feedback taps, and the stamp-ordering helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bw_stream_checker_pkg;

  // Width of the sequence stamp carried in the low bits of every beat.
  localparam int c_STAMP_W = 64;

  // Default number of beats per measured burst.
  localparam logic [31:0] c_BURST_BEATS_DEF = 32'h0200_0000;

  // Throttle LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A stamp is out of order when it does not move strictly forward by less
  // than half the stamp space. Modular subtraction makes an all-ones -> 0
  // wrap look like a forward step of one.
  function automatic logic stamp_delta_bad(input logic [c_STAMP_W-1:0] stamp,
                                           input logic [c_STAMP_W-1:0] prev);
    logic [c_STAMP_W-1:0] delta;
    delta = stamp - prev;
    return (delta == '0) || delta[c_STAMP_W-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bw_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : bw_stream_checker_if
// Purpose : AXI-Stream style beat interface into the bandwidth checker.
// Ports   : IN_AXIS_TDATA  - payload, bits [63:0] hold the sequence stamp
//           IN_AXIS_TVALID - beat valid
//           IN_AXIS_TLAST  - packet end, expected on every beat
//           IN_AXIS_TREADY - checker ready (driven by the slave side)
// Revision: 1.0 - initial release
// ============================================================================
interface bw_stream_checker_if #(
  parameter int DATA_W = 256
) ();

  logic [DATA_W-1:0] IN_AXIS_TDATA;
  logic              IN_AXIS_TVALID;
  logic              IN_AXIS_TLAST;
  logic              IN_AXIS_TREADY;

  modport master (
    output IN_AXIS_TDATA,
    output IN_AXIS_TVALID,
    output IN_AXIS_TLAST,
    input  IN_AXIS_TREADY
  );

  modport slave (
    input  IN_AXIS_TDATA,
    input  IN_AXIS_TVALID,
    input  IN_AXIS_TLAST,
    output IN_AXIS_TREADY
  );

endinterface
`default_nettype wire

// File: rtl/bw_stream_checker_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : bw_lfsr16
// Purpose : 16-bit Fibonacci LFSR used to generate pseudo-random backpressure
//           for the stream checker. Steps on every clock outside reset.
// Ports   : clk          - clock
//           rst          - asynchronous active-high reset (loads the seed)
//           o_lfsr_next  - value the register takes on the next clock edge
// Revision: 1.0 - initial release
// ============================================================================
module bw_lfsr16
  import bw_stream_checker_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  output logic      [15:0] o_lfsr_next
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback  = ^(r_lfsr & c_LFSR_TAPS);
  assign o_lfsr_next = {r_lfsr[14:0], w_feedback};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= c_LFSR_SEED;
    end else begin
      r_lfsr <= o_lfsr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bw_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : bw_stream_checker
// Purpose : Measures the cycle time of fixed-length bursts on a stream and
//           checks that each beat carries TLAST and a strictly increasing
//           64-bit sequence stamp.
// Config  : BW_CHECK_THROTTLE_EN - when defined, an LFSR (bw_lfsr16) drops
//           IN_AXIS_TREADY on roughly a quarter of cycles; when undefined,
//           IN_AXIS_TREADY is 1 whenever not in reset.
// Ports   : clock            - sole clock
//           reset            - asynchronous active-high reset
//           axis             - stream slave (TDATA/TVALID/TLAST in, TREADY out)
//           burst_time       - first-to-last acceptance cycles, last burst
//           burst_done       - one-cycle pulse after a burst completes
//           bursts_done      - completed-burst count (wraps)
//           beat_count       - beats accepted in the current burst
//           error_count      - saturating count of bad beats
//           first_error_data - stamp of the first bad beat since reset
// Revision: 1.0 - initial release
// ============================================================================
module bw_stream_checker
  import bw_stream_checker_pkg::*;
#(
  parameter logic [31:0] BURST_BEATS = c_BURST_BEATS_DEF,
  parameter int          DATA_W      = 256
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  bw_stream_checker_if.slave         axis,
  output logic      [c_STAMP_W-1:0]  burst_time,
  output logic                       burst_done,
  output logic      [31:0]           bursts_done,
  output logic      [31:0]           beat_count,
  output logic      [31:0]           error_count,
  output logic      [c_STAMP_W-1:0]  first_error_data
);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_STAMP_W-1:0] r_cycle;
  logic [c_STAMP_W-1:0] r_start;
  logic [c_STAMP_W-1:0] r_prev;
  logic [c_STAMP_W-1:0] r_burst_time;
  logic [c_STAMP_W-1:0] r_first_error;
  logic                 r_err_seen;
  logic                 r_burst_done;
  logic [31:0]          r_bursts_done;
  logic [31:0]          r_beat_count;
  logic [31:0]          r_error_count;
  logic                 r_ready;

  logic                 w_ready_nxt;
  logic                 w_accept;
  logic                 w_bad;
  logic                 w_complete;
  logic [31:0]          w_count_nxt;
  logic [c_STAMP_W-1:0] w_stamp;
  logic [c_STAMP_W-1:0] w_burst_start;

  assign w_stamp  = axis.IN_AXIS_TDATA[c_STAMP_W-1:0];
  assign w_accept = axis.IN_AXIS_TVALID & r_ready;

  // Payload bits above the stamp are not inspected.
  generate
    if (DATA_W > c_STAMP_W) begin : g_wide_payload
      logic w_payload_unused;
      assign w_payload_unused = ^axis.IN_AXIS_TDATA[DATA_W-1:c_STAMP_W];
    end else begin : g_stamp_only
    end
  endgenerate

`ifdef BW_CHECK_THROTTLE_EN
  logic [15:0] w_lfsr_next;
  logic        w_lfsr_unused;

  bw_lfsr16 u_lfsr (
    .clk         (clock),
    .rst         (reset),
    .o_lfsr_next (w_lfsr_next)
  );

  // Ready is registered from the LFSR's next value, so in every cycle it
  // tracks the low bits of the LFSR register for that same cycle.
  assign w_ready_nxt   = (w_lfsr_next[1:0] != 2'b00);
  assign w_lfsr_unused = ^w_lfsr_next[15:2];
`else
  assign w_ready_nxt = 1'b1;
`endif

  // In IDLE the count is 0, so the same increment yields the first beat.
  assign w_count_nxt = r_beat_count + 32'd1;

  // A burst that starts and ends on the same beat measures zero cycles.
  assign w_burst_start = (r_state == ST_IDLE) ? r_cycle : r_start;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, beat classification and completion
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_bad       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // No predecessor in this burst, so only TLAST is checked.
          w_bad = ~axis.IN_AXIS_TLAST;
          if (w_count_nxt == BURST_BEATS) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_bad = ~axis.IN_AXIS_TLAST | stamp_delta_bad(w_stamp, r_prev);
          if (w_count_nxt == BURST_BEATS) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: cycle counter, burst bookkeeping and error capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle       <= '0;
      r_start       <= '0;
      r_prev        <= '0;
      r_burst_time  <= '0;
      r_first_error <= '0;
      r_err_seen    <= 1'b0;
      r_burst_done  <= 1'b0;
      r_bursts_done <= '0;
      r_beat_count  <= '0;
      r_error_count <= '0;
      r_ready       <= 1'b0;
    end else begin
      r_cycle      <= r_cycle + 64'd1;
      r_ready      <= w_ready_nxt;
      r_burst_done <= w_complete;

      if (w_accept) begin
        r_prev       <= w_stamp;
        r_beat_count <= w_complete ? 32'd0 : w_count_nxt;
        if (r_state == ST_IDLE) begin
          r_start <= r_cycle;
        end
      end

      if (w_complete) begin
        r_burst_time  <= r_cycle - w_burst_start;
        r_bursts_done <= r_bursts_done + 32'd1;
      end

      if (w_bad) begin
        if (r_error_count != 32'hFFFF_FFFF) begin
          r_error_count <= r_error_count + 32'd1;
        end
        if (!r_err_seen) begin
          r_first_error <= w_stamp;
          r_err_seen    <= 1'b1;
        end
      end
    end
  end

  assign axis.IN_AXIS_TREADY = r_ready;
  assign burst_time          = r_burst_time;
  assign burst_done          = r_burst_done;
  assign bursts_done         = r_bursts_done;
  assign beat_count          = r_beat_count;
  assign error_count         = r_error_count;
  assign first_error_data    = r_first_error;

endmodule
`default_nettype wire

// File: tb/tb_bw_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_bw_stream_checker
// Purpose : Self-checking bench for bw_stream_checker with BURST_BEATS = 4.
//           Directed vector table, hand-written reset sequences and a
//           randomized run against a queue-based reference model.
// Config  : BW_CHECK_THROTTLE_EN - selects the backpressure run instead of
//           the fixed-timing directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bw_stream_checker;

  localparam logic [31:0] c_BB = 32'd4;
  localparam int          c_DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bw_stream_checker_if #(.DATA_W(c_DW)) axis ();

  logic [63:0] burst_time;
  logic        burst_done;
  logic [31:0] bursts_done;
  logic [31:0] beat_count;
  logic [31:0] error_count;
  logic [63:0] first_error_data;

  bw_stream_checker #(
    .BURST_BEATS (c_BB),
    .DATA_W      (c_DW)
  ) dut (
    .clock            (clk),
    .reset            (rst),
    .axis             (axis),
    .burst_time       (burst_time),
    .burst_done       (burst_done),
    .bursts_done      (bursts_done),
    .beat_count       (beat_count),
    .error_count      (error_count),
    .first_error_data (first_error_data)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [63:0] s);
    logic [c_DW-1:0] d;
    for (int i = 0; i < c_DW / 32; i++) d[i*32 +: 32] = $urandom;
    d[63:0] = s;
    axis.IN_AXIS_TDATA  = d;
    axis.IN_AXIS_TVALID = v;
    axis.IN_AXIS_TLAST  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_all(input string tag, input logic [31:0] eb, input logic ed,
                         input logic [31:0] ebs, input logic [31:0] ee,
                         input logic [63:0] et, input logic [63:0] ef);
    chk({tag, " beat_count"},       64'(beat_count),  64'(eb));
    chk({tag, " burst_done"},       64'(burst_done),  64'(ed));
    chk({tag, " bursts_done"},      64'(bursts_done), 64'(ebs));
    chk({tag, " error_count"},      64'(error_count), 64'(ee));
    chk({tag, " burst_time"},       burst_time,       et);
    chk({tag, " first_error_data"}, first_error_data, ef);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    bit          v;
    bit          l;
    logic [63:0] s;
    logic [31:0] e_beat;
    bit          e_done;
    logic [31:0] e_bursts;
    logic [31:0] e_err;
    logic [63:0] e_time;
    logic [63:0] e_first;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit v, bit l, logic [63:0] s, logic [31:0] eb,
                              bit ed, logic [31:0] ebs, logic [31:0] ee,
                              logic [63:0] et, logic [63:0] ef);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.s = s;
    x.e_beat = eb; x.e_done = ed; x.e_bursts = ebs;
    x.e_err = ee; x.e_time = et; x.e_first = ef;
    return x;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: the current burst is a queue of accepted beats
  // --------------------------------------------------------------------------
  typedef struct {
    longint unsigned cyc;
    logic [63:0]     stamp;
  } beat_t;

  beat_t           mq[$];
  longint unsigned m_cyc;
  logic [31:0]     m_bursts;
  logic [31:0]     m_err;
  logic [63:0]     m_time;
  logic [63:0]     m_first;
  bit              m_seen;
  bit              m_done;

  task automatic model_reset();
    mq.delete();
    m_cyc = 0; m_bursts = 0; m_err = 0; m_time = 0;
    m_first = 0; m_seen = 0; m_done = 0;
  endtask

  // One clock of stimulus with model update and full output check.
  // Returns whether TREADY was low during the cycle.
  task automatic run_cycle(input logic v, input logic l, input logic [63:0] s,
                           output bit stalled);
    bit          acc;
    bit          bad;
    logic [63:0] d;
    beat_t       b;
    drive(v, l, s);
    stalled = (axis.IN_AXIS_TREADY !== 1'b1);
    acc     = v && !stalled;
    tick();
    m_cyc++;
    m_done = 0;
    if (acc) begin
      bad = !l;
      if (mq.size() > 0) begin
        d = s - mq[mq.size()-1].stamp;
        if (d == 64'd0 || d >= 64'h8000_0000_0000_0000) bad = 1;
      end
      if (bad) begin
        if (m_err != 32'hFFFF_FFFF) m_err++;
        if (!m_seen) begin m_seen = 1; m_first = s; end
      end
      b.cyc = m_cyc; b.stamp = s;
      mq.push_back(b);
      if (mq.size() == int'(c_BB)) begin
        m_time = 64'(m_cyc - mq[0].cyc);
        m_bursts++;
        m_done = 1;
        mq.delete();
      end
    end
    chk_all($sformatf("rnd cyc%0d", m_cyc), 32'(mq.size()), m_done, m_bursts,
            m_err, m_time, m_first);
  endtask

  initial begin
    logic [63:0] sgen;
    bit          st;
    int          lows;
    int          r;

    drive(1'b0, 1'b1, 64'd0);

    // Reset state while reset is held through a clock edge.
    tick();
    chk("reset tready", 64'(axis.IN_AXIS_TREADY), 64'd0);
    chk_all("reset", 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 64'd0);

`ifndef BW_CHECK_THROTTLE_EN
    // A: clean burst. B: duplicate + backwards stamp. C: stamp wrap.
    // D: TLAST=0 and a 5-cycle gap. E: back-to-back burst whose first
    // stamp goes backwards (not checked in IDLE).
    tbl.push_back(mk(1,1,1,64'd10, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd11, 2,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd12, 3,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd13, 0,1,1,0,3,0));
    tbl.push_back(mk(0,0,1,64'd14, 0,0,1,0,3,0));
    tbl.push_back(mk(1,1,1,64'd10, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd11, 2,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd11, 3,0,0,1,0,11));
    tbl.push_back(mk(0,1,1,64'd9,  0,1,1,2,3,11));
    tbl.push_back(mk(1,1,1,64'hFFFF_FFFF_FFFF_FFFE, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'hFFFF_FFFF_FFFF_FFFF, 2,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd0,  3,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,64'd1,  0,1,1,0,3,0));
    tbl.push_back(mk(1,1,1,64'd1,  1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,64'd2,  2,0,0,1,0,2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,64'd3, 2,0,0,1,0,2));
    tbl.push_back(mk(0,1,1,64'd3,  3,0,0,1,0,2));
    tbl.push_back(mk(0,1,1,64'd4,  0,1,1,1,8,2));
    tbl.push_back(mk(0,1,1,64'd2,  1,0,1,1,8,2));
    tbl.push_back(mk(0,1,1,64'd3,  2,0,1,1,8,2));
    tbl.push_back(mk(0,1,1,64'd4,  3,0,1,1,8,2));
    tbl.push_back(mk(0,1,1,64'd5,  0,1,2,1,3,2));
    tbl.push_back(mk(0,0,1,64'd0,  0,0,2,1,3,2));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v, tbl[i].l, tbl[i].s);
      tick();
      chk($sformatf("row%0d tready", i), 64'(axis.IN_AXIS_TREADY), 64'd1);
      chk_all($sformatf("row%0d", i), tbl[i].e_beat, tbl[i].e_done, tbl[i].e_bursts,
              tbl[i].e_err, tbl[i].e_time, tbl[i].e_first);
    end

    // Reset mid-burst: two beats in, assert reset away from any edge and
    // expect every output cleared without waiting for a clock.
    drive(1'b1, 1'b1, 64'd20); tick();
    drive(1'b1, 1'b1, 64'd21); tick();
    chk("midburst beat_count", 64'(beat_count), 64'd2);
    drive(1'b0, 1'b1, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async tready", 64'(axis.IN_AXIS_TREADY), 64'd0);
    chk_all("async", 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("pre-edge tready", 64'(axis.IN_AXIS_TREADY), 64'd0);
    tick();
    chk("post-edge tready", 64'(axis.IN_AXIS_TREADY), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 64'(20 + i));
      tick();
    end
    chk_all("after-reset burst", 32'd0, 1'b1, 32'd1, 32'd0, 64'd3, 64'd0);
`else
    // Backpressure: TVALID held for 1000 cycles, stamp advances only on
    // acceptance so every beat is good.
    do_reset();
    model_reset();
    lows = 0;
    sgen = 64'd100;
    for (int i = 0; i < 1000; i++) begin
      run_cycle(1'b1, 1'b1, sgen, st);
      if (st) lows++;
      else sgen = sgen + 64'd1;
    end
    chk("throttle low cycles in 200..300", 64'(lows >= 200 && lows <= 300), 64'd1);
    chk("throttle error_count", 64'(error_count), 64'd0);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    sgen = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      sgen = sgen;
      else if (r == 1) sgen = {$urandom, $urandom};
      else if (r == 2) sgen = sgen - 64'd1;
      else             sgen = sgen + 64'($urandom_range(1, 3));
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) != 0, sgen, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
